// File: rtl/pwm_generator_if.sv
// Control and status bundle for pwm_generator.
// The master drives configuration/enable; the slave (generator) returns the waveform and status.
interface pwm_generator_if #(
    parameter int unsigned WIDTH = 16
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] period_in;
    logic [WIDTH-1:0] high_in;
    logic             pwm_out;
    logic             cycle_start;
    logic             busy;
    logic             cfg_err;

    modport master (
        output enable, load, period_in, high_in,
        input  pwm_out, cycle_start, busy, cfg_err
    );

    modport slave (
        input  enable, load, period_in, high_in,
        output pwm_out, cycle_start, busy, cfg_err
    );
endinterface

// File: rtl/pwm_generator.sv
// PWM generator with shadowed configuration applied at period boundaries.
// Waveform outputs are registered from the next-cycle state and counter.
module pwm_generator #(
    parameter int unsigned WIDTH = 16
) (
    input logic          clk,
    input logic          reset,
    pwm_generator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n, cnt_inc;
    logic [WIDTH-1:0] per_s, high_s, per_a, high_a;
    logic [WIDTH-1:0] per_s_n, high_s_n, per_a_n, high_a_n;
    logic [WIDTH-1:0] src_per, src_high;
    logic             pending, pending_n;
    logic             err_q, err_n;
    logic             pwm_q, pwm_n;
    logic             cs_q, cs_n;
    logic             load_ok, last, transfer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            per_s   <= '0;
            high_s  <= '0;
            per_a   <= '0;
            high_a  <= '0;
            pending <= 1'b0;
            err_q   <= 1'b0;
            pwm_q   <= 1'b0;
            cs_q    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            per_s   <= per_s_n;
            high_s  <= high_s_n;
            per_a   <= per_a_n;
            high_a  <= high_a_n;
            pending <= pending_n;
            err_q   <= err_n;
            pwm_q   <= pwm_n;
            cs_q    <= cs_n;
        end
    end

    always_comb begin
        load_ok   = bus.load && (bus.period_in != '0);
        last      = (cnt == per_a - WIDTH'(1));
        transfer  = (state == IDLE) || last;
        cnt_inc   = cnt + WIDTH'(1);
        src_per   = load_ok ? bus.period_in : per_s;
        src_high  = load_ok ? bus.high_in   : high_s;

        per_s_n   = per_s;
        high_s_n  = high_s;
        per_a_n   = per_a;
        high_a_n  = high_a;
        pending_n = pending;
        err_n     = err_q;
        state_n   = state;
        cnt_n     = cnt;

        if (bus.load)
            err_n = !load_ok;
        if (load_ok) begin
            per_s_n  = bus.period_in;
            high_s_n = bus.high_in;
        end

        // A load landing on a transfer cycle bypasses the shadow straight into active.
        if (transfer && (load_ok || pending)) begin
            per_a_n   = src_per;
            high_a_n  = src_high;
            pending_n = 1'b0;
        end else if (load_ok) begin
            pending_n = 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.enable && (per_a_n != '0))
                    state_n = RUN;
            end
            RUN: begin
                if (last) begin
                    cnt_n   = '0;
                    state_n = bus.enable ? RUN : IDLE;
                end else begin
                    cnt_n   = cnt_inc;
                    state_n = bus.enable ? RUN : DRAIN;
                end
            end
            DRAIN: begin
                if (last) begin
                    cnt_n   = '0;
                    state_n = bus.enable ? RUN : IDLE;
                end else begin
                    cnt_n   = cnt_inc;
                    state_n = bus.enable ? RUN : DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        pwm_n = (state_n != IDLE) && (cnt_n < high_a_n);
        cs_n  = (state_n != IDLE) && (cnt_n == '0);
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.cycle_start = cs_q;
    assign bus.busy        = (state != IDLE);
    assign bus.cfg_err     = err_q;
endmodule
